// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: assembles SYNC/ADDR/DHI/DLO/CSUM frames from the
// byte receiver and issues one config-register write per valid frame.
module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'h55,
    parameter int unsigned TIMEOUT_CYC = 521000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_int,
    input  logic [7:0]  rx_data,
    input  logic        rx_en,
    output logic        cfg_we,
    output logic [3:0]  cfg_addr,
    output logic [15:0] cfg_wdata,
    output logic        frm_err,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CSUM
    } state_t;

    state_t        state;
    logic          rx_int_q;
    logic          byte_stb;
    logic          csum_ok;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    addr_q;
    logic [7:0]    dhi_q;
    logic [7:0]    dlo_q;

    // rx_data is only valid in the strobe cycle, so all byte decisions use it directly here
    always_comb begin
        byte_stb = rx_int_q & ~rx_int;
        csum_ok  = (rx_data == (addr_q ^ dhi_q ^ dlo_q)) && (addr_q[7:4] == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rx_int_q  <= 1'b0;
            tmo_cnt   <= '0;
            addr_q    <= 8'd0;
            dhi_q     <= 8'd0;
            dlo_q     <= 8'd0;
            cfg_we    <= 1'b0;
            cfg_addr  <= 4'd0;
            cfg_wdata <= 16'd0;
            frm_err   <= 1'b0;
            err_cnt   <= 8'd0;
            busy      <= 1'b0;
        end else begin
            rx_int_q <= rx_int;
            cfg_we   <= 1'b0;
            frm_err  <= 1'b0;

            if (!rx_en) begin
                // Disabled: abandon any partial frame silently
                state   <= S_IDLE;
                busy    <= 1'b0;
                tmo_cnt <= '0;
            end else if (state == S_IDLE) begin
                tmo_cnt <= '0;
                if (byte_stb && (rx_data == SYNC_BYTE)) begin
                    state <= S_ADDR;
                    busy  <= 1'b1;
                end
            end else if (byte_stb) begin
                // A byte arriving on the terminal count still wins over the timeout
                tmo_cnt <= '0;
                case (state)
                    S_ADDR: begin
                        addr_q <= rx_data;
                        state  <= S_DHI;
                    end
                    S_DHI: begin
                        dhi_q <= rx_data;
                        state <= S_DLO;
                    end
                    S_DLO: begin
                        dlo_q <= rx_data;
                        state <= S_CSUM;
                    end
                    S_CSUM: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (csum_ok) begin
                            cfg_we    <= 1'b1;
                            cfg_addr  <= addr_q[3:0];
                            cfg_wdata <= {dhi_q, dlo_q};
                        end else begin
                            frm_err <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                tmo_cnt <= '0;
                frm_err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller behind the RS-232 byte receiver. It watches the receiver's `rx_int`/`rx_data` pair and captures each completed byte. It assembles fixed 5-byte command frames, checks the checksum and issues one register-write strobe per valid frame to the triangulation configuration registers. It also runs an inter-byte timeout and counts framing errors.

## Interface
- `SYNC_BYTE`, default 8'h55: frame start marker.
- `TIMEOUT_CYC`, default 521000: idle clocks allowed between bytes inside a frame; about 10 byte times at 9600 baud on a 50 MHz clock.
- `clk`, input, 1: 50 MHz system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx_int`, input, 1: high while the receiver is busy with a byte.
- `rx_data`, input, 8: receiver byte. Valid only in the first cycle `rx_int` is low after being high; it is forced to 0 otherwise.
- `rx_en`, input, 1: frame parsing enable.
- `cfg_we`, output, 1: one-cycle write strobe.
- `cfg_addr`, output, 4: register address. Held until the next write.
- `cfg_wdata`, output, 16: register data. Held until the next write.
- `frm_err`, output, 1: one-cycle pulse on a checksum, address or timeout error.
- `err_cnt`, output, 8: saturating error count.
- `busy`, output, 1: high while a frame is in progress (state not IDLE).

## Operation
- Byte strobe `byte_stb` = `rx_int_q & ~rx_int`, where `rx_int_q` is `rx_int` registered once.
- `rx_data` is sampled combinationally in the `byte_stb` cycle. It reads 0 one cycle later, so it must not be sampled late.
- Frame format: SYNC, ADDR, DHI, DLO, CSUM, with CSUM = ADDR ^ DHI ^ DLO.
- ADDR[7:4] must be 0.
- State machine: IDLE, ADDR, DHI, DLO, CSUM.
  - IDLE: on `byte_stb` with byte == SYNC_BYTE, go to ADDR. Any other byte is discarded silently and is not counted as an error.
  - ADDR: on `byte_stb`, latch the address byte and go to DHI.
  - DHI: latch the high data byte and go to DLO.
  - DLO: latch the low data byte and go to CSUM.
  - CSUM, checksum matches and ADDR[7:4] == 0: pulse `cfg_we`, load `cfg_addr`/`cfg_wdata`, go to IDLE.
  - CSUM, any mismatch: pulse `frm_err`, leave `cfg_*` unchanged, go to IDLE.
- Timeout counter:
  - Cleared on every `byte_stb` and whenever the state is IDLE.
  - Counts otherwise.
  - On reaching TIMEOUT_CYC-1 in a non-IDLE state: go to IDLE and pulse `frm_err`.
- A byte in SYNC position is not special mid-frame. A 0x55 arriving as ADDR/DHI/DLO/CSUM is treated as data.
- `rx_en` low: state forced to IDLE, timeout counter cleared, `byte_stb` ignored. A partial frame is abandoned without an error.
- `err_cnt` increments on each `frm_err` and saturates at 8'hFF.

## Timing
- Reset values: state IDLE; `cfg_we` 0; `cfg_addr` 0; `cfg_wdata` 0; `frm_err` 0; `err_cnt` 0; `busy` 0; `rx_int_q` 0; timeout counter 0.
- `rx_int` falls at cycle T, which is the `byte_stb` cycle. The state register updates at the end of T.
- `cfg_we`/`frm_err` are registered. They are high during T+1 for the CSUM byte received at T, and `cfg_addr`/`cfg_wdata` are valid from T+1.
- Timeout: counter equals TIMEOUT_CYC-1 in cycle C. Then `frm_err` is high in C+1, `busy` is low from C+1, and `err_cnt` is updated in C+1.
- Simultaneous `byte_stb` and timeout terminal count: the byte wins. It is processed, the counter is cleared and no error is raised.
- `frm_err` and `cfg_we` are never high in the same cycle.
- Asynchronous reset mid-frame: everything returns to reset values immediately, including `cfg_*` and `err_cnt`.

## Test plan
- Valid frame: bytes 55 03 12 34 25 -> `cfg_we` one cycle high, `cfg_addr`=3, `cfg_wdata`=16'h1234, `err_cnt`=0, `busy` low after.
- Bad checksum: bytes 55 03 12 34 26 -> `frm_err` one pulse, no `cfg_we`, `err_cnt`=1, `cfg_*` keep previous values.
- Bad address: bytes 55 13 00 00 13 -> checksum correct but ADDR[7:4]≠0, so `frm_err` pulses, `err_cnt`+1, no write.
- Timeout: with TIMEOUT_CYC=100, send 55 03, then no `rx_int` for 100 cycles -> `frm_err` exactly once, state IDLE. A following valid frame 55 05 AB CD 63 then writes addr 5, data 16'hABCD.
- Noise and abort: leading bytes 00 FF before 55 07 00 01 06 -> garbage ignored with no error, write to addr 7, data 16'h0001. Then send 55 07 and drop `rx_en` -> IDLE with no `frm_err`.
- Saturation and reset: force 300 bad frames -> `err_cnt`=FF. Assert `rst_n` low mid-frame -> all outputs 0 immediately.
